// File: rtl/clock_seq_gate.sv
// clock_seq_gate
//   Power-up clock sequencer. It releases NUM_CH gated copies of clk_in one
//   channel at a time after en_req rises. It withdraws them in reverse order
//   after en_req falls. Each gate enable is re-timed on the falling edge of
//   clk_in, so a gated clock only ever shows whole high phases.
//
// Ports
//   clk_in   in   1       source clock (rising edge, except the gate register)
//   rst      in   1       synchronous active-high reset
//   en_req   in   1       level request: 1 = sequence up, 0 = sequence down
//   clk_out  out  NUM_CH  gated clocks, clk_out[i] = clk_in & gate_q[i]
//   ch_en    out  NUM_CH  registered thermometer of enabled channels
//   all_on   out  1       every channel enabled and state ON
//   all_off  out  1       no channel enabled and state OFF
//   busy     out  1       state is WAIT_START, RAMP_UP or RAMP_DOWN
module clock_seq_gate #(
    parameter int NUM_CH      = 4,
    parameter int PRE_DIV     = 50,
    parameter int START_TICKS = 10,
    parameter int STEP_TICKS  = 2,
    parameter int TICK_W      = 16
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              en_req,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] ch_en,
    output logic              all_on,
    output logic              all_off,
    output logic              busy
);

    localparam int LVL_W = $clog2(NUM_CH + 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_WAIT_START,
        S_RAMP_UP,
        S_ON,
        S_RAMP_DOWN
    } state_t;

    state_t             st, st_nxt;
    logic [TICK_W-1:0]  pre;
    logic [TICK_W-1:0]  tk;
    logic [LVL_W-1:0]   lvl, lvl_nxt;
    logic               tick;
    logic               step_clr;
    logic [NUM_CH-1:0]  ch_en_nxt;
    logic [NUM_CH-1:0]  gate_q;

    assign tick = (pre == TICK_W'(PRE_DIV - 1));

    // Next state and level. A change of en_req is tested before the tick,
    // so it wins when both happen in the same cycle.
    always_comb begin
        st_nxt   = st;
        lvl_nxt  = lvl;
        step_clr = 1'b0;
        case (st)
            S_OFF: begin
                if (en_req) st_nxt = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (!en_req) begin
                    st_nxt = S_OFF;
                end else if (tick && tk == TICK_W'(START_TICKS - 1)) begin
                    lvl_nxt = LVL_W'(1);
                    st_nxt  = (NUM_CH == 1) ? S_ON : S_RAMP_UP;
                end
            end
            S_RAMP_UP: begin
                if (!en_req) begin
                    lvl_nxt = lvl - LVL_W'(1);
                    st_nxt  = (lvl == LVL_W'(1)) ? S_OFF : S_RAMP_DOWN;
                end else if (tick && tk == TICK_W'(STEP_TICKS - 1)) begin
                    lvl_nxt  = lvl + LVL_W'(1);
                    step_clr = 1'b1;
                    if (lvl + LVL_W'(1) == LVL_W'(NUM_CH)) st_nxt = S_ON;
                end
            end
            S_ON: begin
                if (!en_req) begin
                    lvl_nxt = lvl - LVL_W'(1);
                    st_nxt  = (lvl == LVL_W'(1)) ? S_OFF : S_RAMP_DOWN;
                end
            end
            S_RAMP_DOWN: begin
                if (en_req) begin
                    st_nxt = S_RAMP_UP;
                end else if (tick && tk == TICK_W'(STEP_TICKS - 1)) begin
                    lvl_nxt  = lvl - LVL_W'(1);
                    step_clr = 1'b1;
                    if (lvl == LVL_W'(1)) st_nxt = S_OFF;
                end
            end
            default: begin
                st_nxt  = S_OFF;
                lvl_nxt = '0;
            end
        endcase
    end

    always_comb begin
        ch_en_nxt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_en_nxt[i] = (32'(lvl_nxt) > i);
        end
    end

    // Status outputs decode the next state and level, so they change on the
    // same edge as ch_en.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            st      <= S_OFF;
            pre     <= '0;
            tk      <= '0;
            lvl     <= '0;
            ch_en   <= '0;
            all_on  <= 1'b0;
            all_off <= 1'b1;
            busy    <= 1'b0;
        end else begin
            st      <= st_nxt;
            lvl     <= lvl_nxt;
            ch_en   <= ch_en_nxt;
            all_on  <= (st_nxt == S_ON) && (lvl_nxt == LVL_W'(NUM_CH));
            all_off <= (st_nxt == S_OFF) && (lvl_nxt == '0);
            busy    <= (st_nxt == S_WAIT_START) || (st_nxt == S_RAMP_UP) ||
                       (st_nxt == S_RAMP_DOWN);
            // A state change restarts the interval so every delay is exact.
            if (st_nxt != st) begin
                pre <= '0;
                tk  <= '0;
            end else if (tick) begin
                pre <= '0;
                tk  <= step_clr ? '0 : tk + TICK_W'(1);
            end else begin
                pre <= pre + TICK_W'(1);
            end
        end
    end

    // Gate enables change only while clk_in is low.
    always_ff @(negedge clk_in) begin
        gate_q <= ch_en;
    end

    assign clk_out = {NUM_CH{clk_in}} & gate_q;

endmodule

// File: tb/tb_clock_seq_gate.sv
// tb_clock_seq_gate
//   Directed bench for clock_seq_gate. Instance a uses NUM_CH=4, PRE_DIV=4,
//   START_TICKS=3 and STEP_TICKS=2. Instance b uses the default timing with
//   NUM_CH=1. Edge numbers count rising edges from the one that first
//   samples the new en_req.
`timescale 1ns/1ps
module tb_clock_seq_gate;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_en;
    logic       b_en;
    logic [3:0] a_clk_out, a_ch_en;
    logic       a_all_on, a_all_off, a_busy;
    logic [0:0] b_clk_out, b_ch_en;
    logic       b_all_on, b_all_off, b_busy;

    int checks = 0;
    int errors = 0;
    int e = 0;

    always #5 clk = ~clk;

    clock_seq_gate #(
        .NUM_CH(4), .PRE_DIV(4), .START_TICKS(3), .STEP_TICKS(2), .TICK_W(16)
    ) dut_a (
        .clk_in(clk), .rst(rst), .en_req(a_en), .clk_out(a_clk_out),
        .ch_en(a_ch_en), .all_on(a_all_on), .all_off(a_all_off), .busy(a_busy)
    );

    clock_seq_gate #(
        .NUM_CH(1)
    ) dut_b (
        .clk_in(clk), .rst(rst), .en_req(b_en), .clk_out(b_clk_out),
        .ch_en(b_ch_en), .all_on(b_all_on), .all_off(b_all_off), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    // Advance to 1ns after rising edge n.
    task automatic run_to(input int n);
        repeat (n - e) @(posedge clk);
        #1;
        e = n;
    endtask

    // Every high pulse on a gated clock must last a full half period.
    logic [3:0] prev_co = '0;
    realtime    rise_t[4];
    always @(a_clk_out) begin
        for (int i = 0; i < 4; i++) begin
            if (a_clk_out[i] === 1'b1 && prev_co[i] !== 1'b1) begin
                rise_t[i] = $realtime;
            end else if (a_clk_out[i] === 1'b0 && prev_co[i] === 1'b1) begin
                checks++;
                assert ($realtime - rise_t[i] >= 5.0) else begin
                    errors++;
                    $error("FAIL glitch clk_out[%0d]: high %0t ns required >= 5 ns", i,
                           $realtime - rise_t[i]);
                end
            end
        end
        prev_co = a_clk_out;
    end

    initial begin
        rst  = 1'b1;
        a_en = 1'b0;
        b_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ch_en", a_ch_en, 4'b0000);
        chk("rst_all_off", a_all_off, 1'b1);
        chk("rst_all_on", a_all_on, 1'b0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_clk_out", a_clk_out, 4'b0000);
        chk("rst_b_all_off", b_all_off, 1'b1);
        rst = 1'b0;

        // Ramp up
        a_en = 1'b1; e = -1;
        run_to(1);  chk("up_busy1", a_busy, 1'b1);
        run_to(11); chk("up_e11", a_ch_en, 4'b0000);
        run_to(12); chk("up_e12", a_ch_en, 4'b0001);
                    chk("up_co_e12", a_clk_out, 4'b0000);
        run_to(13); chk("up_co_e13", a_clk_out, 4'b0001);
        run_to(19); chk("up_e19", a_ch_en, 4'b0001);
        run_to(20); chk("up_e20", a_ch_en, 4'b0011);
        run_to(28); chk("up_e28", a_ch_en, 4'b0111);
        run_to(35); chk("up_e35", a_ch_en, 4'b0111);
                    chk("up_busy35", a_busy, 1'b1);
                    chk("up_all_on35", a_all_on, 1'b0);
        run_to(36); chk("up_e36", a_ch_en, 4'b1111);
                    chk("up_all_on36", a_all_on, 1'b1);
                    chk("up_busy36", a_busy, 1'b0);
        run_to(37); chk("up_co_e37", a_clk_out, 4'b1111);

        // Ramp down, en_req=0 sampled at T=41
        run_to(40); a_en = 1'b0;
        run_to(41); chk("dn_T", a_ch_en, 4'b0111);
                    chk("dn_all_on", a_all_on, 1'b0);
                    chk("dn_busy", a_busy, 1'b1);
        run_to(48); chk("dn_T7", a_ch_en, 4'b0111);
        run_to(49); chk("dn_T8", a_ch_en, 4'b0011);
        run_to(57); chk("dn_T16", a_ch_en, 4'b0001);
        run_to(64); chk("dn_off_T23", a_all_off, 1'b0);
        run_to(65); chk("dn_T24", a_ch_en, 4'b0000);
                    chk("dn_all_off", a_all_off, 1'b1);
                    chk("dn_busy_end", a_busy, 1'b0);

        // Abort at edge 25, run all the way down
        a_en = 1'b1; e = -1;
        run_to(24); chk("ab_e24", a_ch_en, 4'b0011);
                    a_en = 1'b0;
        run_to(25); chk("ab_e25", a_ch_en, 4'b0001);
        run_to(32); chk("ab_e32", a_ch_en, 4'b0001);
        run_to(33); chk("ab_e33", a_ch_en, 4'b0000);
                    chk("ab_all_off", a_all_off, 1'b1);
        run_to(36); chk("ab_busy", a_busy, 1'b0);

        // Abort at edge 25, re-raise at edge 30
        a_en = 1'b1; e = -1;
        run_to(24); a_en = 1'b0;
        run_to(25); chk("rr_e25", a_ch_en, 4'b0001);
        run_to(29); a_en = 1'b1;
        run_to(30); chk("rr_e30", a_ch_en, 4'b0001);
                    chk("rr_busy30", a_busy, 1'b1);
        run_to(37); chk("rr_e37", a_ch_en, 4'b0001);
        run_to(38); chk("rr_e38", a_ch_en, 4'b0011);
                    chk("rr_co_e38", a_clk_out, 4'b0001);
        run_to(39); chk("rr_co_e39", a_clk_out, 4'b0011);

        // Reset mid RAMP_UP with ch_en=0011
        rst = 1'b1;
        run_to(40); chk("mr_ch_en", a_ch_en, 4'b0000);
                    chk("mr_all_off", a_all_off, 1'b1);
                    chk("mr_busy", a_busy, 1'b0);
                    rst = 1'b0; a_en = 1'b0;
        run_to(41); chk("mr_clk_out", a_clk_out, 4'b0000);
        a_en = 1'b1; e = -1;
        run_to(11); chk("mr_re_e11", a_ch_en, 4'b0000);
        run_to(12); chk("mr_re_e12", a_ch_en, 4'b0001);
        run_to(14); a_en = 1'b0;

        // NUM_CH=1 with default timing
        b_en = 1'b1; e = -1;
        run_to(499); chk("b_e499", b_ch_en, 1'b0);
                     chk("b_busy499", b_busy, 1'b1);
        run_to(500); chk("b_e500", b_ch_en, 1'b1);
                     chk("b_all_on", b_all_on, 1'b1);
                     chk("b_busy500", b_busy, 1'b0);
                     b_en = 1'b0;
        run_to(501); chk("b_off_ch", b_ch_en, 1'b0);
                     chk("b_all_off", b_all_off, 1'b1);
                     chk("b_off_busy", b_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_seq_gate.md
# clock_seq_gate

Parametrised power-up clock sequencer with glitch-free per-channel clock gating. After `en_req` rises, it releases NUM_CH gated copies of `clk_in` one channel at a time, at programmable intervals, so downstream chips see a staged, power-safe clock start. When `en_req` falls, it withdraws the channels in reverse order. It sits between the board oscillator input and the per-device clock nets.

## Interface
Parameters:
- NUM_CH, default 4: number of gated clock channels (legal range 1..16).
- PRE_DIV, default 50: prescaler period in `clk_in` cycles; one tick every PRE_DIV cycles (must be ≥1).
- START_TICKS, default 10: ticks from sequence start to channel 0 enable (must be ≥1).
- STEP_TICKS, default 2: ticks between successive channel enables/disables (must be ≥1).
- TICK_W, default 16: width of the prescaler and tick counters; must hold max(PRE_DIV, START_TICKS, STEP_TICKS).

Ports (reset rst, synchronous, active-high; clock clk_in):
- clk_in  input  1  source clock; every register is on its rising edge, except the gate-enable register.
- rst  input  1  synchronous active-high reset.
- en_req  input  1  level request: high = sequence up, low = sequence down.
- clk_out  output  NUM_CH  gated clocks; clk_out[i] = clk_in & gate_q[i].
- ch_en  output  NUM_CH  registered thermometer of enabled channels (bit i set implies bits 0..i-1 set).
- all_on  output  1  high when all NUM_CH channels are enabled and the state is ON.
- all_off  output  1  high when no channel is enabled and the state is OFF.
- busy  output  1  high in WAIT_START, RAMP_UP and RAMP_DOWN.

## Operation
- Internal state: FSM {OFF, WAIT_START, RAMP_UP, ON, RAMP_DOWN}; prescaler `pre`; tick counter `tk`; level counter `lvl` (0..NUM_CH); ch_en[i] = (i < lvl).
- Prescaler: `pre` counts 0..PRE_DIV-1. `tick` is high for the one cycle where pre==PRE_DIV-1, then `pre` wraps to 0. `tk` increments on each tick.
- Any FSM state change clears `pre` and `tk` on the same edge, so every interval is exact.
- OFF: if en_req=1, go to WAIT_START.
- WAIT_START:
  - en_req=0: go to OFF.
  - tick with tk==START_TICKS-1: set lvl to 1. Go to ON if NUM_CH==1, otherwise RAMP_UP.
- RAMP_UP:
  - tick with tk==STEP_TICKS-1: increment lvl and clear tk.
  - When lvl reaches NUM_CH, go to ON.
  - en_req=0: go to RAMP_DOWN and decrement lvl on that same edge.
- ON: if en_req=0, go to RAMP_DOWN and decrement lvl on that same edge. If lvl becomes 0, go straight to OFF.
- RAMP_DOWN:
  - tick with tk==STEP_TICKS-1: decrement lvl and clear tk.
  - When lvl reaches 0, go to OFF.
  - en_req=1: go to RAMP_UP. The next enable comes STEP_TICKS ticks later; no immediate increment.
- Glitch-free gating: gate_q[i] captures ch_en[i] on the falling edge of clk_in. clk_out therefore never shows a runt pulse.
- Simultaneous events: an en_req change takes priority over a tick in the same cycle.

## Timing
- Reset values on the first rising edge with rst high: lvl=0, ch_en=0, all_on=0, all_off=1, busy=0, state OFF, pre=tk=0.
- gate_q clears at the following falling edge; clk_out is 0 from then on.
- rst asserted mid-sequence: all channels drop on the same reset edge and clk_out stops at the next falling edge. There is no reverse ramp.
- Let edge 0 be the edge at which en_req=1 is sampled in OFF. Channel k's ch_en rises at edge (START_TICKS + k·STEP_TICKS)·PRE_DIV.
- all_on rises on the same edge as ch_en[NUM_CH-1].
- Let edge T be the edge at which en_req=0 is sampled in ON. ch_en[NUM_CH-1-j] falls at edge T + j·STEP_TICKS·PRE_DIV.
- all_off rises on the same edge as ch_en[0] falls.
- A channel's ch_en rises at edge E. clk_out[i] goes high at the next rising edge and every one after, with full-width high phases.
- ch_en/all_on/all_off/busy: all registered, no combinational path from en_req.

## Test plan
- Ramp up (NUM_CH=4, PRE_DIV=4, START_TICKS=3, STEP_TICKS=2): en_req=1 at edge 0 -> ch_en becomes 0001@12, 0011@20, 0111@28, 1111@36. all_on=1@36; busy=1 from edge 1 to 35.
- Ramp down (same config): en_req=0 sampled at T in ON -> ch_en becomes 0111@T, 0011@T+8, 0001@T+16, 0000@T+24. all_off=1@T+24.
- Abort: drop en_req at edge 25, when ch_en=0011 -> 0001@25, 0000@33, then OFF. Raise en_req at edge 30 in RAMP_DOWN -> 0011@38, with no glitch on clk_out[1].
- Glitch check: for every ch_en transition, no clk_out high pulse may be shorter than half a period of clk_in (checker on both edges).
- Reset mid-RAMP_UP with ch_en=0011 -> rst edge: ch_en=0, all_off=1, busy=0. clk_out is 0 after the next falling edge. Restart gives channel 0 at edge 12 again.
- Default params with NUM_CH=1: en_req=1 -> ch_en[0] rises at edge 500 and the state goes directly to ON, with all_on=1@500.
